alu_seq_exec: RTL and testbench

//   Execution end of the 4-bit ALU operation-select code produced by the ALU sub-control decoder.

---
 rtl/alu_seq_exec.sv | 128 ++++++++++++
 tb/tb_alu_seq_exec.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: executes one decoded ALU op (logic/arith/compare/shift) per valid/ready request.
// Latency: logic/arith/compare/illegal -> out_valid 1 cycle after accept; shift by k -> 2+k cycles.
// Backpressure: single request in flight; in_ready low until the result is taken, outputs frozen while out_ready=0.
// Ports: clk/rst_n (async active-low); in_valid/in_ready with outsel, op_a, op_b;
//        out_valid/out_ready with result, zero, illegal.
module alu_seq_exec #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      outsel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHAMT_W-1:0] CNT_ONE = 1;

  state_t              state, state_nxt;
  logic [XLEN-1:0]     shreg;
  logic [SHAMT_W-1:0]  cnt;
  logic [1:0]          sh_kind;   // outsel[1:0] of the shift code: 01 SLL, 10 SRL, 11 SRA
  logic [XLEN-1:0]     res_q;
  logic                zero_q;
  logic                ill_q;

  logic [XLEN-1:0]     alu_res;
  logic                alu_ill;
  logic                is_shift;
  logic                accept;

  // single-cycle datapath; illegal codes yield a zero result
  always_comb begin
    alu_res  = '0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    case (outsel)
      4'b0000: alu_res = op_a & op_b;
      4'b0001: alu_res = op_a | op_b;
      4'b0010: alu_res = op_a + op_b;
      4'b0110: alu_res = op_a - op_b;
      4'b1100: alu_res = op_a ^ op_b;
      4'b0111: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b1000: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      4'b1001, 4'b1010, 4'b1011: is_shift = 1'b1;
      default: alu_ill = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;

  // next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = is_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      cnt     <= '0;
      sh_kind <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      ill_q   <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        if (is_shift) begin
          shreg   <= op_a;
          cnt     <= op_b[SHAMT_W-1:0];
          sh_kind <= outsel[1:0];
        end else begin
          res_q  <= alu_res;
          zero_q <= (alu_res == '0);
          ill_q  <= alu_ill;
        end
      end else if (state == SHIFT) begin
        if (cnt != '0) begin
          case (sh_kind)
            2'b01:   shreg <= {shreg[XLEN-2:0], 1'b0};
            2'b10:   shreg <= {1'b0, shreg[XLEN-1:1]};
            default: shreg <= {shreg[XLEN-1], shreg[XLEN-1:1]};
          endcase
          cnt <= cnt - CNT_ONE;
        end else begin
          // shifting finished: publish the shift register as the result
          res_q  <= shreg;
          zero_q <= (shreg == '0);
          ill_q  <= 1'b0;
        end
      end
    end
  end

  assign result  = res_q;
  assign zero    = zero_q;
  assign illegal = ill_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed vectors for alu_seq_exec with a queue-based scoreboard.
// Driver pushes the hand-computed result/flags/latency on acceptance; monitor pops on each output transfer.
// Also covers reset state, output hold under backpressure and reset abort of an in-flight shift.
module tb_alu_seq_exec;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  outsel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  alu_seq_exec #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .outsel    (outsel),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  typedef struct {
    logic [31:0] res;
    logic        zr;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   nvec  = 0;
  int   nfail = 0;
  int   cyc   = 0;
  int   first_cyc = 0;
  bit   seen  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // monitor: compare on every completed output transfer
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !seen) begin
        seen      = 1;
        first_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL unexpected_output: got result 0x%08h, expected no output", result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result",  result, e.res);
          chk("zero",    {31'b0, zero}, {31'b0, e.zr});
          chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
          chk("latency", first_cyc - e.acc + 1, e.lat);
        end
        seen = 0;
      end
    end else begin
      seen = 0;
    end
  end

  // present a request, wait for acceptance, then scramble the inputs
  task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic ill, input int lat, input bit expect_out);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    outsel   = sel;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      nvec++;
      nfail++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1 within 200 cycles");
      in_valid = 1'b0;
    end else begin
      if (expect_out) begin
        e.res = r;
        e.zr  = (r == 32'h0);
        e.ill = ill;
        e.lat = lat;
        e.acc = cyc + 1;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      outsel   = 4'b1111;
      op_a     = 32'hFFFF_FFFF;
      op_b     = 32'hFFFF_FFFF;
    end
  endtask

  task automatic drain;
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      nvec++;
      nfail++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    outsel    = 4'b0;
    op_a      = 32'h0;
    op_b      = 32'h0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_result",    result,             32'd0);
    chk("rst_zero",      {31'b0, zero},      32'd1);
    chk("rst_illegal",   {31'b0, illegal},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // sel, a, b, expected result, illegal, latency
    issue(4'b0010, 32'd5,          32'd7,          32'd12,         1'b0, 1,  1'b1); // ADD
    issue(4'b0110, 32'h3,          32'h3,          32'h0,          1'b0, 1,  1'b1); // SUB -> zero
    issue(4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1,  1'b1); // SLT -1<1
    issue(4'b1000, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1,  1'b1); // SLTU
    issue(4'b0111, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1,  1'b1); // SLT 1<-1
    issue(4'b0000, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  1'b0, 1,  1'b1); // AND
    issue(4'b0001, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'hFFF0_FFF0,  1'b0, 1,  1'b1); // OR
    issue(4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1,  1'b1); // ADD wrap
    issue(4'b0110, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1,  1'b1); // SUB wrap
    issue(4'b1001, 32'd1,          32'd31,         32'h8000_0000,  1'b0, 33, 1'b1); // SLL 31
    issue(4'b1011, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 6,  1'b1); // SRA 4
    issue(4'b1010, 32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 6,  1'b1); // SRL 4
    issue(4'b1001, 32'h0000_1234,  32'h0000_0020,  32'h0000_1234,  1'b0, 2,  1'b1); // shamt 0
    issue(4'b1111, 32'd5,          32'd6,          32'd0,          1'b1, 1,  1'b1); // illegal
    issue(4'b0011, 32'd5,          32'd6,          32'd0,          1'b1, 1,  1'b1); // illegal
    issue(4'b0010, 32'd1,          32'd2,          32'd3,          1'b0, 1,  1'b1); // after illegal
    drain();

    // backpressure: XOR result held with out_ready low
    out_ready = 1'b0;
    issue(4'b1100, 32'h0000_F0F0,  32'h0000_FFFF,  32'h0000_0F0F,  1'b0, 1,  1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_result",    result,             32'h0000_0F0F);
      chk("bp_in_ready",  {31'b0, in_ready},  32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_release_in_ready",  {31'b0, in_ready},  32'd1);
    drain();

    // reset mid-shift: no result may appear afterwards
    issue(4'b1001, 32'd1, 32'd20, 32'd0, 1'b0, 0, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready",  {31'b0, in_ready},  32'd1);
    chk("abort_result",    result,             32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("abort_idle_out_valid", {31'b0, out_valid}, 32'd0);

    issue(4'b0010, 32'd100, 32'd23, 32'd123, 1'b0, 1, 1'b1); // after abort
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
